vector_lane_seq: RTL and testbench
==================================

Name: vector_lane_seq

Overview:
- Multi-cycle sequencer between the decode/register-read stage and the 16-bit lane floating-point ALU.
- Takes 256-bit vector operands (16 lanes × 16-bit half-precision) and presents one lane per cycle to the lane ALU.
- Collects per-lane results into a 256-bit result buffer.
- For VDOT, also runs a serial reduction of the lane products through the ALU's add path, producing a scalar.

Parameters:
- LANES, 16, number of lanes per vector.
- LANE_W, 16, lane width in bits (half-precision float).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin an operation. Sampled only when busy=0.
- opcode  in  4  0000 VADD, 0001 VDOT, 0010 SMUL. Any other value is unsupported.
- vec_a  in  256  operand A. Lane k is bits [16k+15:16k].
- vec_b  in  256  operand B, same lane layout.
- busy  out  1  high while in MAP or REDUCE.
- done  out  1  one-cycle pulse when result is valid.
- result  out  256  final result. Held until the next completion.
- lane_valid  out  1  lane operands are valid this cycle.
- lane_op  out  4  opcode driven to the lane ALU.
- lane_a  out  16  lane operand A.
- lane_b  out  16  lane operand B.
- lane_result  in  16  lane ALU result. Combinational, same cycle as lane_a/lane_b.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; busy=0, done=0, result=0; lane_valid=0, lane_op=0000, lane_a=0, lane_b=0; lane index=0; accumulator=0.
- States: IDLE, MAP, REDUCE, DONE.
- Start acceptance:
  - start is accepted on a rising edge when the state is IDLE or DONE (edge E0).
  - On acceptance, latch opcode, vec_a and vec_b; clear the lane index.
  - start while busy=1 is ignored and has no effect on the latched operands.
- Unsupported opcode: on acceptance, go to DONE. done=1 in cycle 1; result updates to 0.
- MAP (cycles 1..16, lane k = cycle-1):
  - lane_valid=1.
  - VADD: lane_op=0000, lane_a=A[k], lane_b=B[k].
  - VDOT: lane_op=0001 (lane multiply), lane_a=A[k], lane_b=B[k].
  - SMUL: lane_op=0010, lane_a=A[0] (scalar broadcast), lane_b=B[k].
  - lane_result is captured into buffer lane k at the end of each cycle.
  - Lane index wraps 15→0 on exit.
- MAP exit:
  - VADD/SMUL: after lane 15, go to DONE. done=1 in cycle 17; result = buffer.
  - VDOT: after lane 15, go to REDUCE. The accumulator is loaded with the lane-0 product (forwarded if captured the same edge).
- REDUCE (cycles 17..31, j = 1..15):
  - lane_valid=1, lane_op=0000, lane_a=accumulator, lane_b=product[j].
  - accumulator <= lane_result each cycle.
  - After j=15, go to DONE. done=1 in cycle 32; result = {240'd0, accumulator}.
- DONE: lasts exactly one cycle. done=1, busy=0, lane_valid=0. Next state is IDLE, or MAP if start is accepted.
- result register:
  - Written only on the transition into DONE.
  - Partial lane results are never visible on result.
  - Holds its value across IDLE and across later operations until the next DONE.
- Lane outputs: lane_a, lane_b and lane_op are driven to 0 whenever lane_valid=0.
- Arithmetic: no arithmetic is performed inside the block. All FP behaviour (rounding, infinity saturation) belongs to the lane ALU. The block only routes and registers 16-bit values.
- rst mid-operation: return to IDLE on the next edge with all reset values. result is cleared to 0 and no done pulse is issued.
- rst and start in the same cycle: rst wins.

Test Plan:
- VADD, all A lanes 0x3C00 (1.0), all B lanes 0x4000 (2.0) → busy cycles 1-16, done only in cycle 17, result = 16×0x4200. lane_a/lane_b step A[k]/B[k] per cycle.
- VDOT, all A lanes 0x3C00, all B lanes 0x4000 → lane_op=0001 for cycles 1-16 and 0000 for cycles 17-31, done in cycle 32, result = {240'd0, 16'h5000} (32.0).
- SMUL, vec_a[15:0]=0x4000 (upper lanes 0xFFFF), all B lanes 0x3C00 → lane_a=0x4000 every MAP cycle, done in cycle 17, result = 16×0x4000.
- VADD running, start asserted with opcode VDOT and new operands at cycle 5 → ignored. Done in cycle 17 with the original VADD result, and no second done.
- VADD running, rst=1 at cycle 8 → cycle 9: IDLE, busy=0, lane_valid=0, result=0, no done. A fresh start then completes normally.
- opcode 0011 → done in cycle 1, busy never high, lane_valid never high, result=0. A back-to-back start accepted in the DONE cycle begins MAP in the next cycle.

Source files
------------

// File: rtl/vector_lane_seq.sv
// Sequencer feeding a 16-bit lane FP ALU one lane per cycle from 256-bit vector
// operands; collects per-lane results and, for VDOT, serially reduces the products.
//
// state  | meaning
// IDLE   | waiting for start
// MAP    | presenting lane idx to the ALU, capturing lane_result into buf
// REDUCE | VDOT only: acc + product[idx+1] through the ALU add path
// DONE   | one-cycle done pulse, result valid; may accept a new start
module vector_lane_seq #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [3:0]                opcode,
  input  logic [LANES*LANE_W-1:0]   vec_a,
  input  logic [LANES*LANE_W-1:0]   vec_b,
  output logic                      busy,
  output logic                      done,
  output logic [LANES*LANE_W-1:0]   result,
  output logic                      lane_valid,
  output logic [3:0]                lane_op,
  output logic [LANE_W-1:0]         lane_a,
  output logic [LANE_W-1:0]         lane_b,
  input  logic [LANE_W-1:0]         lane_result
);

  localparam int VEC_W = LANES * LANE_W;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(LANES - 1);
  localparam logic [IDX_W-1:0] IDX_RED_LAST = IDX_W'(LANES - 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MAP    = 2'd1;
  localparam logic [1:0] S_REDUCE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] OP_VADD = 4'b0000;
  localparam logic [3:0] OP_VDOT = 4'b0001;
  localparam logic [3:0] OP_SMUL = 4'b0010;

  logic [1:0]        state_q,  state_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [VEC_W-1:0]  a_q,      a_d;
  logic [VEC_W-1:0]  b_q,      b_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [LANE_W-1:0] acc_q,    acc_d;
  logic [VEC_W-1:0]  buf_q,    buf_d;
  logic [VEC_W-1:0]  result_q, result_d;

  logic [IDX_W-1:0]  red_idx;

  function automatic logic op_supported(input logic [3:0] op);
    return (op == OP_VADD) || (op == OP_VDOT) || (op == OP_SMUL);
  endfunction

  // REDUCE walks products 1..LANES-1 while idx counts from 0
  assign red_idx = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    buf_d    = buf_q;
    result_d = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          opcode_d = opcode;
          a_d      = vec_a;
          b_d      = vec_b;
          idx_d    = '0;
          if (op_supported(opcode)) begin
            state_d = S_MAP;
          end else begin
            state_d  = S_DONE;
            result_d = '0;
          end
        end
      end

      S_MAP: begin
        buf_d[32'(idx_q)*LANE_W +: LANE_W] = lane_result;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          if (opcode_q == OP_VDOT) begin
            state_d = S_REDUCE;
            // buf_d carries the lane-0 product even if it is captured this edge
            acc_d   = buf_d[LANE_W-1:0];
          end else begin
            state_d  = S_DONE;
            result_d = buf_d;
          end
        end
      end

      S_REDUCE: begin
        acc_d = lane_result;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_RED_LAST) begin
          idx_d    = '0;
          state_d  = S_DONE;
          result_d = {{(VEC_W-LANE_W){1'b0}}, lane_result};
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      buf_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      buf_q    <= buf_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    lane_valid = 1'b0;
    lane_op    = '0;
    lane_a     = '0;
    lane_b     = '0;
    case (state_q)
      S_MAP: begin
        lane_valid = 1'b1;
        lane_op    = opcode_q;
        lane_a     = (opcode_q == OP_SMUL) ? a_q[LANE_W-1:0]
                                           : a_q[32'(idx_q)*LANE_W +: LANE_W];
        lane_b     = b_q[32'(idx_q)*LANE_W +: LANE_W];
      end
      S_REDUCE: begin
        lane_valid = 1'b1;
        lane_op    = OP_VADD;
        lane_a     = acc_q;
        lane_b     = buf_q[32'(red_idx)*LANE_W +: LANE_W];
      end
      default: ;
    endcase
  end

  assign busy   = (state_q == S_MAP) || (state_q == S_REDUCE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_vector_lane_seq.sv
// Bench for vector_lane_seq: a small FP16 lane-ALU model drives lane_result, and a
// negedge monitor checks lane traffic and done/result against queued expectations.
module tb_vector_lane_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   opcode;
  logic [255:0] vec_a, vec_b;
  logic         busy, done;
  logic [255:0] result;
  logic         lane_valid;
  logic [3:0]   lane_op;
  logic [15:0]  lane_a, lane_b;
  logic [15:0]  lane_result;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          cyc;
  } lane_t;

  typedef struct packed {
    logic [255:0] res;
    int           cyc;
  } done_t;

  lane_t lane_q[$];
  done_t done_q[$];
  lane_t le;
  done_t de;

  // running sums 2.0, 4.0 .. 30.0 in half precision
  logic [15:0] acc_tab [15] = '{16'h4000, 16'h4400, 16'h4600, 16'h4800, 16'h4900,
                                16'h4A00, 16'h4B00, 16'h4C00, 16'h4C80, 16'h4D00,
                                16'h4D80, 16'h4E00, 16'h4E80, 16'h4F00, 16'h4F80};

  vector_lane_seq dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .vec_a(vec_a), .vec_b(vec_b), .busy(busy), .done(done), .result(result),
    .lane_valid(lane_valid), .lane_op(lane_op), .lane_a(lane_a), .lane_b(lane_b),
    .lane_result(lane_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Lane ALU stand-in: positive normal operands only, truncating
  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic [10:0] ma, mb;
    logic [21:0] p;
    logic [6:0]  e;
    logic [9:0]  m;
    ma = {1'b1, a[9:0]};
    mb = {1'b1, b[9:0]};
    p  = 22'(ma) * 22'(mb);
    e  = 7'(a[14:10]) + 7'(b[14:10]) - 7'd15;
    if (p[21]) begin e = e + 7'd1; m = p[20:11]; end
    else m = p[19:10];
    return {a[15] ^ b[15], e[4:0], m};
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] a, b;
    logic [4:0]  ea;
    logic [11:0] ma, mb, s;
    if (x == 16'h0) return y;
    if (y == 16'h0) return x;
    if (x[14:10] >= y[14:10]) begin a = x; b = y; end
    else begin a = y; b = x; end
    ea = a[14:10];
    ma = {2'b01, a[9:0]};
    mb = {2'b01, b[9:0]} >> (a[14:10] - b[14:10]);
    s  = ma + mb;
    if (s[11]) return {1'b0, ea + 5'd1, s[10:1]};
    return {1'b0, ea, s[9:0]};
  endfunction

  always_comb begin
    lane_result = 16'h0;
    case (lane_op)
      4'b0000: lane_result = fp_add(lane_a, lane_b);
      4'b0001, 4'b0010: lane_result = fp_mul(lane_a, lane_b);
      default: lane_result = 16'h0;
    endcase
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name, input string got, input string want);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %s expected %s (cycle %0d)", name, got, want, cyc);
  endtask

  function automatic logic [255:0] rep(input logic [15:0] v);
    return {16{v}};
  endfunction

  // Monitor: decoupled from stimulus, pops expectations whenever the DUT presents them
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy_eq_lane_valid", 256'(busy), 256'(lane_valid));
      if (lane_valid) begin
        if (lane_q.size() == 0) fail_evt("unexpected_lane", "lane_valid=1", "lane_valid=0");
        else begin
          le = lane_q.pop_front();
          chk("lane_cycle", 256'(cyc), 256'(le.cyc));
          chk("lane_op_a_b", {lane_op, lane_a, lane_b}, {le.op, le.a, le.b});
        end
      end else begin
        chk("lane_idle_zero", {lane_op, lane_a, lane_b}, 256'd0);
      end
      if (done) begin
        if (done_q.size() == 0) fail_evt("unexpected_done", "done=1", "done=0");
        else begin
          de = done_q.pop_front();
          chk("done_cycle", 256'(cyc), 256'(de.cyc));
          chk("result", result, de.res);
          chk("done_busy", 256'(busy), 256'd0);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [255:0] a, input logic [255:0] b,
                       output int t0);
    @(posedge clk); #1;
    start = 1'b1; opcode = op; vec_a = a; vec_b = b;
    t0 = cyc;
  endtask

  task automatic release_start();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_map(input logic [3:0] op, input logic [255:0] a, input logic [255:0] b,
                          input int base);
    lane_t e;
    for (int k = 0; k < 16; k++) begin
      e.op  = op;
      e.a   = (op == 4'b0010) ? a[15:0] : a[k*16 +: 16];
      e.b   = b[k*16 +: 16];
      e.cyc = base + 1 + k;
      lane_q.push_back(e);
    end
  endtask

  task automatic push_reduce(input logic [15:0] prod, input int base);
    lane_t e;
    for (int j = 1; j < 16; j++) begin
      e.op  = 4'b0000;
      e.a   = acc_tab[j-1];
      e.b   = prod;
      e.cyc = base + 16 + j;
      lane_q.push_back(e);
    end
  endtask

  task automatic push_done(input logic [255:0] res, input int c);
    done_t e;
    e.res = res;
    e.cyc = c;
    done_q.push_back(e);
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && done_q.size() != 0; i++) @(posedge clk);
    if (done_q.size() != 0) begin
      fail_evt("drain_timeout", "done pending", "all done pulses seen");
      done_q.delete();
      lane_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    logic [255:0] smul_a;
    rst = 1'b1; start = 1'b0; opcode = 4'h0; vec_a = '0; vec_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 256'(busy), 256'd0);
    chk("reset_done", 256'(done), 256'd0);
    chk("reset_result", result, 256'd0);
    chk("reset_lane", {lane_valid, lane_op, lane_a, lane_b}, 256'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // VADD 1.0 + 2.0
    issue(4'b0000, rep(16'h3C00), rep(16'h4000), t0);
    push_map(4'b0000, rep(16'h3C00), rep(16'h4000), t0);
    push_done(rep(16'h4200), t0 + 17);
    release_start();
    wait_drain(60);

    // VDOT 16 x (1.0 * 2.0) = 32.0
    issue(4'b0001, rep(16'h3C00), rep(16'h4000), t0);
    push_map(4'b0001, rep(16'h3C00), rep(16'h4000), t0);
    push_reduce(16'h4000, t0);
    push_done({240'd0, 16'h5000}, t0 + 32);
    release_start();
    wait_drain(80);

    // SMUL broadcast of lane 0, upper A lanes must be ignored
    smul_a = {{15{16'hFFFF}}, 16'h4000};
    issue(4'b0010, smul_a, rep(16'h3C00), t0);
    push_map(4'b0010, smul_a, rep(16'h3C00), t0);
    push_done(rep(16'h4000), t0 + 17);
    release_start();
    wait_drain(60);

    // VADD with a stray VDOT start at cycle 5
    issue(4'b0000, rep(16'h3C00), rep(16'h4000), t0);
    push_map(4'b0000, rep(16'h3C00), rep(16'h4000), t0);
    push_done(rep(16'h4200), t0 + 17);
    release_start();
    repeat (4) @(posedge clk);
    #1;
    chk("busy_at_cycle5", 256'(busy), 256'd1);
    start = 1'b1; opcode = 4'b0001; vec_a = rep(16'h4000); vec_b = rep(16'h4400);
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain(60);
    repeat (40) @(posedge clk);

    // VADD aborted by rst in cycle 8
    issue(4'b0000, rep(16'h3C00), rep(16'h4000), t0);
    for (int k = 0; k < 8; k++) begin
      le.op = 4'b0000; le.a = 16'h3C00; le.b = 16'h4000; le.cyc = t0 + 1 + k;
      lane_q.push_back(le);
    end
    release_start();
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 256'(busy), 256'd0);
    chk("abort_lane_valid", 256'(lane_valid), 256'd0);
    chk("abort_result", result, 256'd0);
    chk("abort_done", 256'(done), 256'd0);
    repeat (5) @(posedge clk);
    issue(4'b0000, rep(16'h4000), rep(16'h4000), t0);
    push_map(4'b0000, rep(16'h4000), rep(16'h4000), t0);
    push_done(rep(16'h4400), t0 + 17);
    release_start();
    wait_drain(60);

    // Unsupported opcode, then back-to-back VADD accepted in the DONE cycle
    issue(4'b0011, rep(16'h1234), rep(16'h5678), t0);
    push_done(256'd0, t0 + 1);
    push_map(4'b0000, rep(16'h3C00), rep(16'h3C00), t0 + 1);
    push_done(rep(16'h4000), t0 + 18);
    @(posedge clk); #1;
    chk("unsup_done_cycle1", 256'(done), 256'd1);
    opcode = 4'b0000; vec_a = rep(16'h3C00); vec_b = rep(16'h3C00);
    release_start();
    chk("b2b_map_busy", 256'(busy), 256'd1);
    wait_drain(60);

    chk("lane_queue_empty", 256'(lane_q.size()), 256'd0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
